// File: rtl/truth_sweep_pkg.sv
// Shared types and constants for the truth table sweeper.
// Contents: sweep FSM state enum, settle counter width, largest supported N_IN.
package truth_sweep_pkg;

  localparam int unsigned SETTLE_CNT_W = 4;
  localparam int unsigned MAX_N_IN     = 6;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } sweep_state_e;

endpackage

// File: rtl/truth_table_sweeper_settle_counter.sv
// Settle wait counter: loadable down-counter with a zero flag.
// Ports: clk, rst_n (async active-low), load/load_val (preset),
//        dec (count down, saturates at zero), zero_c (count == 0).
module settle_counter
  import truth_sweep_pkg::*;
#(
  parameter int unsigned W = SETTLE_CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero_c
);

  logic [W-1:0] count_q;

  // Load takes priority over decrement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (dec && (count_q != '0)) begin
      count_q <= count_q - W'(1);
    end
  end

  assign zero_c = (count_q == '0);

endmodule

// File: rtl/truth_table_sweeper.sv
// Truth table sweeper: drives every input vector of a small combinational
// function, waits SETTLE_CYCLES per vector, captures f into truth_tbl and,
// when built with TRUTH_SWEEP_COMPARE_EN, compares against a golden table.
// Ports: clk, rst_n (async active-low), start, abort, f, expected (golden),
//        abc (vector driven, MSB = A), busy, done (1-cycle pulse),
//        table_valid, truth_tbl, pass, first_mismatch.
// Macro TRUTH_SWEEP_COMPARE_EN: builds the compare logic; without it
// pass/first_mismatch stay 0 and expected is ignored.
module truth_table_sweeper
  import truth_sweep_pkg::*;
#(
  parameter int unsigned N_IN          = 3,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   f,
  input  logic [(1<<N_IN)-1:0]   expected,
  output logic [N_IN-1:0]        abc,
  output logic                   busy,
  output logic                   done,
  output logic                   table_valid,
  output logic [(1<<N_IN)-1:0]   truth_tbl,
  output logic                   pass,
  output logic [N_IN-1:0]        first_mismatch
);

  localparam int unsigned TBL_W       = 1 << N_IN;
  // Counter holds the remaining settle cycles minus one when SETTLE is entered.
  localparam int unsigned SETTLE_LOAD = (SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0;

  // Parameter range guard.
  if ((N_IN < 1) || (N_IN > MAX_N_IN) || (SETTLE_CYCLES > ((1 << SETTLE_CNT_W) - 1)))
  begin : g_bad_param
    $error("truth_table_sweeper: parameter out of range");
  end

  sweep_state_e        state_q, state_d;
  logic [N_IN-1:0]     abc_q, abc_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                tv_q, tv_d;
  logic [TBL_W-1:0]    tbl_q, tbl_d;
  logic                pass_q, pass_d;
  logic [N_IN-1:0]     fm_q, fm_d;

  logic                cnt_load;
  logic                cnt_dec;
  logic                cnt_zero_c;
  logic                cmp_pass_c;
  logic [N_IN-1:0]     cmp_fm_c;

  settle_counter #(.W(SETTLE_CNT_W)) u_settle_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (SETTLE_CNT_W'(SETTLE_LOAD)),
    .dec      (cnt_dec),
    .zero_c   (cnt_zero_c)
  );

  // Golden-table comparison on the captured table.
`ifdef TRUTH_SWEEP_COMPARE_EN
  logic [TBL_W-1:0] diff_c;

  always_comb begin
    diff_c     = tbl_q ^ expected;
    cmp_pass_c = (diff_c == '0);
    cmp_fm_c   = '0;
    // Scan downward so the lowest differing index wins.
    for (int i = int'(TBL_W) - 1; i >= 0; i--) begin
      if (diff_c[i]) cmp_fm_c = N_IN'(i);
    end
  end
`else
  logic unused_expected;
  assign unused_expected = ^expected;
  assign cmp_pass_c      = 1'b0;
  assign cmp_fm_c        = '0;
`endif

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      abc_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      tv_q    <= 1'b0;
      tbl_q   <= '0;
      pass_q  <= 1'b0;
      fm_q    <= '0;
    end else begin
      state_q <= state_d;
      abc_q   <= abc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      tv_q    <= tv_d;
      tbl_q   <= tbl_d;
      pass_q  <= pass_d;
      fm_q    <= fm_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d  = state_q;
    abc_d    = abc_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    tv_d     = tv_q;
    tbl_d    = tbl_q;
    pass_d   = pass_q;
    fm_d     = fm_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Abort in the same cycle drops the start request.
        if (start && !abort) begin
          abc_d  = '0;
          busy_d = 1'b1;
          tv_d   = 1'b0;
          tbl_d  = '0;
          if (SETTLE_CYCLES == 0) begin
            state_d = ST_SAMPLE;
          end else begin
            state_d  = ST_SETTLE;
            cnt_load = 1'b1;
          end
        end
      end

      ST_SETTLE: begin
        if (abort) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else if (cnt_zero_c) begin
          state_d = ST_SAMPLE;
        end else begin
          cnt_dec = 1'b1;
        end
      end

      ST_SAMPLE: begin
        if (abort) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else begin
          tbl_d[abc_q] = f;
          // No wrap: the last vector ends the sweep instead of incrementing.
          if (abc_q != '1) begin
            abc_d = abc_q + N_IN'(1);
            if (SETTLE_CYCLES == 0) begin
              state_d = ST_SAMPLE;
            end else begin
              state_d  = ST_SETTLE;
              cnt_load = 1'b1;
            end
          end else begin
            state_d = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        tv_d    = 1'b1;
        pass_d  = cmp_pass_c;
        fm_d    = cmp_fm_c;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign abc            = abc_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign table_valid    = tv_q;
  assign truth_tbl      = tbl_q;
  assign pass           = pass_q;
  assign first_mismatch = fm_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper: one instance with SETTLE_CYCLES=2
// and one with SETTLE_CYCLES=0, both sweeping f = (A & B) | C.
module tb_truth_table_sweeper;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic       start0;
  logic [7:0] expected;

  logic       f;
  logic [2:0] abc;
  logic       busy, done, table_valid, pass;
  logic [7:0] truth_tbl;
  logic [2:0] first_mismatch;

  logic       f0;
  logic [2:0] abc0;
  logic       busy0, done0, table_valid0, pass0;
  logic [7:0] truth_tbl0;
  logic [2:0] first_mismatch0;

  int checks = 0;
  int errors = 0;

  assign f  = (abc[2] & abc[1]) | abc[0];
  assign f0 = (abc0[2] & abc0[1]) | abc0[0];

  truth_table_sweeper #(.N_IN(3), .SETTLE_CYCLES(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .abort          (abort),
    .f              (f),
    .expected       (expected),
    .abc            (abc),
    .busy           (busy),
    .done           (done),
    .table_valid    (table_valid),
    .truth_tbl      (truth_tbl),
    .pass           (pass),
    .first_mismatch (first_mismatch)
  );

  truth_table_sweeper #(.N_IN(3), .SETTLE_CYCLES(0)) dut0 (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start0),
    .abort          (1'b0),
    .f              (f0),
    .expected       (expected),
    .abc            (abc0),
    .busy           (busy0),
    .done           (done0),
    .table_valid    (table_valid0),
    .truth_tbl      (truth_tbl0),
    .pass           (pass0),
    .first_mismatch (first_mismatch0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1, "watchdog");
  end

  // Pulse start on dut, run to done; returns cycles after the accept edge.
  task automatic sweep(input logic [7:0] e, output int cyc);
    expected = e;
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    cyc = 0;
    while (done !== 1'b1 && cyc < 60) begin
      @(posedge clk); cyc++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; start0 = 1'b0; expected = 8'h00;
    repeat (2) @(negedge clk);
    checks++;
    if ({abc, busy, done, table_valid, truth_tbl, pass, first_mismatch} !== 17'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h want 0",
               {abc, busy, done, table_valid, truth_tbl, pass, first_mismatch});
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || table_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b done=%b tv=%b want 0 0 0", busy, done, table_valid);
    end
  endtask

  task automatic test_sweep();
    int  cyc;
    bit  abc_bad;
    expected = 8'hEA;
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    checks++;
    if (busy !== 1'b1 || abc !== 3'd0) begin
      errors++;
      $display("FAIL sweep_accept: busy=%b abc=%0d want 1 0", busy, abc);
    end
    cyc = 0; abc_bad = 1'b0;
    while (done !== 1'b1 && cyc < 60) begin
      if (cyc < 24 && abc !== 3'(cyc / 3)) abc_bad = 1'b1;
      @(posedge clk); cyc++;
      @(negedge clk);
    end
    checks++;
    if (abc_bad) begin
      errors++;
      $display("FAIL sweep_abc_steps: abc did not hold each of 0..7 for 3 cycles");
    end
    checks++;
    if (cyc != 25) begin
      errors++;
      $display("FAIL sweep_done_cycle: got %0d want 25", cyc);
    end
    checks++;
    if (truth_tbl !== 8'hEA || table_valid !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL sweep_result: tbl=%h tv=%b busy=%b want ea 1 0", truth_tbl, table_valid, busy);
    end
`ifdef TRUTH_SWEEP_COMPARE_EN
    checks++;
    if (pass !== 1'b1 || first_mismatch !== 3'd0) begin
      errors++;
      $display("FAIL sweep_pass_ea: pass=%b fm=%0d want 1 0", pass, first_mismatch);
    end
`else
    checks++;
    if (pass !== 1'b0 || first_mismatch !== 3'd0) begin
      errors++;
      $display("FAIL sweep_pass_off: pass=%b fm=%0d want 0 0", pass, first_mismatch);
    end
`endif
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || table_valid !== 1'b1) begin
      errors++;
      $display("FAIL done_pulse_width: done=%b tv=%b want 0 1", done, table_valid);
    end
  endtask

  task automatic test_compare();
    int cyc;
    sweep(8'hEB, cyc);
    checks++;
`ifdef TRUTH_SWEEP_COMPARE_EN
    if (cyc != 25 || pass !== 1'b0 || first_mismatch !== 3'd0 || truth_tbl !== 8'hEA) begin
      errors++;
      $display("FAIL compare_eb: cyc=%0d pass=%b fm=%0d tbl=%h want 25 0 0 ea",
               cyc, pass, first_mismatch, truth_tbl);
    end
`else
    if (cyc != 25 || pass !== 1'b0 || first_mismatch !== 3'd0 || truth_tbl !== 8'hEA) begin
      errors++;
      $display("FAIL compare_eb_off: cyc=%0d pass=%b fm=%0d tbl=%h want 25 0 0 ea",
               cyc, pass, first_mismatch, truth_tbl);
    end
`endif
    sweep(8'hE8, cyc);
    checks++;
`ifdef TRUTH_SWEEP_COMPARE_EN
    if (cyc != 25 || pass !== 1'b0 || first_mismatch !== 3'd1) begin
      errors++;
      $display("FAIL compare_e8: cyc=%0d pass=%b fm=%0d want 25 0 1", cyc, pass, first_mismatch);
    end
`else
    if (cyc != 25 || pass !== 1'b0 || first_mismatch !== 3'd0) begin
      errors++;
      $display("FAIL compare_e8_off: cyc=%0d pass=%b fm=%0d want 25 0 0", cyc, pass, first_mismatch);
    end
`endif
  endtask

  task automatic test_abort();
    int  n;
    bit  saw_done;
    expected = 8'hEA;
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    n = 0;
    while (abc !== 3'd3 && n < 60) begin
      @(negedge clk); n++;
    end
    checks++;
    if (abc !== 3'd3) begin
      errors++;
      $display("FAIL abort_reach_abc3: abc=%0d want 3", abc);
    end
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || table_valid !== 1'b0 || truth_tbl !== 8'h02) begin
      errors++;
      $display("FAIL abort_state: busy=%b tv=%b tbl=%h want 0 0 02", busy, table_valid, truth_tbl);
    end
    saw_done = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) begin
      errors++;
      $display("FAIL abort_no_done: done/busy seen after abort, want none");
    end
    // Start and abort together in IDLE: nothing happens.
    start = 1'b1; abort = 1'b1;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || truth_tbl !== 8'h02) begin
      errors++;
      $display("FAIL start_abort_idle: busy=%b tbl=%h want 0 02", busy, truth_tbl);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    expected = 8'hEA;
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    cyc = 0;
    while (done !== 1'b1 && cyc < 60) begin
      start = (cyc == 16) ? 1'b1 : 1'b0;   // re-start while abc == 5
      abort = (cyc == 24) ? 1'b1 : 1'b0;   // abort while in DONE
      @(posedge clk); cyc++;
      @(negedge clk);
    end
    start = 1'b0; abort = 1'b0;
    checks++;
    if (cyc != 25 || truth_tbl !== 8'hEA || table_valid !== 1'b1) begin
      errors++;
      $display("FAIL back_to_back: cyc=%0d tbl=%h tv=%b want 25 ea 1", cyc, truth_tbl, table_valid);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL back_to_back_idle: busy=%b want 0", busy);
    end
  endtask

  task automatic test_settle0();
    int cyc;
    bit saw_done;
    @(negedge clk); start0 = 1'b1;
    @(posedge clk);
    @(negedge clk); start0 = 1'b0;
    cyc = 0;
    while (done0 !== 1'b1 && cyc < 60) begin
      @(posedge clk); cyc++;
      @(negedge clk);
    end
    checks++;
    if (cyc != 9 || truth_tbl0 !== 8'hEA || table_valid0 !== 1'b1) begin
      errors++;
      $display("FAIL settle0_sweep: cyc=%0d tbl=%h tv=%b want 9 ea 1", cyc, truth_tbl0, table_valid0);
    end
    // Mid-sweep reset.
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({abc0, busy0, done0, table_valid0, truth_tbl0, pass0, first_mismatch0} !== 17'd0) begin
      errors++;
      $display("FAIL settle0_async_reset: got %h want 0",
               {abc0, busy0, done0, table_valid0, truth_tbl0, pass0, first_mismatch0});
    end
    @(negedge clk); rst_n = 1'b1;
    saw_done = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (done0 === 1'b1 || busy0 === 1'b1) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) begin
      errors++;
      $display("FAIL settle0_no_done_after_reset: done/busy seen, want none");
    end
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_compare();
    test_abort();
    test_back_to_back();
    test_settle0();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/truth_table_sweeper.md
TRUTH_TABLE_SWEEPER -- requirements
Module: truth_table_sweeper

Interface
REQ-001 Parameter N_IN, default 3: number of inputs of the combinational function under test (range 1..6).
REQ-002 Parameter SETTLE_CYCLES, default 2: wait cycles after driving a vector before sampling f (range 0..15).
REQ-003 clk  input  1  rising-edge clock; sole clock.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle sweep request; honoured only in IDLE.
REQ-006 abort  input  1  terminates a sweep in progress.
REQ-007 f  input  1  output of the function under test, sampled synchronously.
REQ-008 expected  input  2**N_IN  golden truth table; bit i is the expected f for vector i.
REQ-009 abc  output  N_IN  registered input vector to the function; MSB is A.
REQ-010 busy  output  1  high from start acceptance until done or abort.
REQ-011 done  output  1  one-cycle pulse when a sweep completes.
REQ-012 table_valid  output  1  high while truth_tbl holds a complete sweep.
REQ-013 truth_tbl  output  2**N_IN  captured f values; bit i holds f for abc==i.
REQ-014 pass  output  1  truth_tbl equals expected; valid while table_valid is high.
REQ-015 first_mismatch  output  N_IN  lowest index where truth_tbl differs from expected; 0 when pass is high.

Function
REQ-016 FSM states: IDLE, SETTLE, SAMPLE, DONE.
REQ-017 IDLE and start high and abort low: abc<=0, busy<=1, table_valid<=0, truth_tbl<=0, go to SETTLE.
REQ-018 SETTLE: count SETTLE_CYCLES cycles with abc stable, then go to SAMPLE; SETTLE_CYCLES=0 goes directly to SAMPLE.
REQ-019 SAMPLE: truth_tbl[abc]<=f. If abc is not all-ones: abc<=abc+1 and go to SETTLE. Otherwise go to DONE.
REQ-020 DONE, one cycle: done=1, busy<=0, table_valid<=1, pass and first_mismatch latched; return to IDLE.
REQ-021 Each vector occupies SETTLE_CYCLES+1 cycles. done is high exactly 1+2**N_IN*(SETTLE_CYCLES+1) cycles after the start-accept edge.
REQ-022 abc has no wrap-around: the increment never occurs from all-ones. abc holds its last value in IDLE.
REQ-023 start while busy is ignored; no restart, no queuing.
REQ-024 abort in SETTLE or SAMPLE: next state is IDLE, busy<=0, no done pulse, table_valid stays 0. The partial truth_tbl is retained.
REQ-025 abort in DONE is ignored; the sweep completes.
REQ-026 start and abort together in IDLE: abort wins and start is dropped.
REQ-027 f is sampled only in SAMPLE; f changes at any other time have no effect.

Reset
REQ-028 rst_n low forces immediately: state=IDLE, abc=0, busy=0, done=0, table_valid=0, truth_tbl=0, pass=0, first_mismatch=0, settle counter=0.
REQ-029 Reset during a sweep discards it; no done pulse follows deassertion.

Configuration
REQ-030 Macro TRUTH_SWEEP_COMPARE_EN defined: comparison logic is built and pass/first_mismatch behave per REQ-014/015/020.
REQ-031 Macro TRUTH_SWEEP_COMPARE_EN undefined: no comparison logic; pass and first_mismatch are tied to 0 and expected is ignored. Port list is unchanged.

Structure
REQ-032 Package truth_sweep_pkg holds the state enum typedef, the SETTLE counter width constant (4), and the max N_IN constant (6).
REQ-033 Sub-module settle_counter: load, count down, and zero flag. It is instantiated once.

Verification
REQ-034 N_IN=3, SETTLE=2, f=(A&B)|C. Pulse start. Expect abc stepping 0..7, each value held 3 cycles; done at cycle 25; truth_tbl=8'hEA.
REQ-035 Same f with expected=8'hEA, macro on. Expect pass=1 and first_mismatch=0. With expected=8'hEB, expect pass=0 and first_mismatch=0. With expected=8'hE8, expect first_mismatch=1.
REQ-036 Assert abort when abc=3. Expect busy=0 the next cycle, no done pulse, table_valid=0, and truth_tbl[2:0] captured.
REQ-037 Pulse start again while busy at abc=5. Expect the sweep to be unaffected and done still at cycle 25.
REQ-038 SETTLE=0. Expect one cycle per vector and done at cycle 9. Drive rst_n low mid-sweep: all outputs 0 immediately, and no done after release.
REQ-039 Macro off. Any f and expected give pass=0 and first_mismatch=0 always; truth_tbl is still correct.
